// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature encoder emulator: FSM states,
// Gray-code phase constants and the position-to-phase mapping.
package quad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  // {A,B} depends only on the two low position bits, so any move stays in phase.
  function automatic logic [1:0] pos_to_phase(input logic [1:0] pos);
    logic [1:0] ph;
    case (pos)
      2'd0:    ph = PH0;
      2'd1:    ph = PH1;
      2'd2:    ph = PH2;
      default: ph = PH3;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/quad_prescaler.sv
// Programmable prescaler: counts 0..div and pulses tick for one cycle on the
// terminal count; clr holds the count at zero and suppresses the tick.
module quad_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = !clr && (cnt == div);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quad_encoder_tx.sv
// Quadrature encoder emulator: steps {quad_a,quad_b} from position to a loaded
// target, one step per prescaler tick. Define QUAD_INDEX_EN for the index output.
module quad_encoder_tx
  import quad_pkg::*;
#(
  parameter int W     = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [W-1:0]     target,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             dir,
  output logic             quad_a,
  output logic             quad_b,
  output logic [W-1:0]     position
`ifdef QUAD_INDEX_EN
  ,
  output logic             index
`endif
);

  // Handshake: load is a one-cycle request, accepted only in IDLE; in RUN or
  // FIN it is dropped and target/divisor are not sampled again.
  state_t           state, next_state;
  logic [W-1:0]     target_q;
  logic [DIV_W-1:0] div_q;
  logic             tick, accept, step;
  logic [W-1:0]     pos_next;
  logic             busy_d, done_d, dir_d;
  logic [1:0]       phase_d;

  quad_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (state != RUN),
    .div   (div_q),
    .tick  (tick)
  );

  assign accept = (state == IDLE) && load;
  assign step   = (state == RUN) && tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (load) begin
          next_state = (target == position) ? FIN : RUN;
        end
      end
      RUN: begin
        if (step && (pos_next == target_q)) begin
          next_state = FIN;
        end
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs, all derived from next_state/pos_next.
  always_comb begin
    pos_next = position;
    if (step) begin
      pos_next = dir ? (position + 1'b1) : (position - 1'b1);
    end
    busy_d  = (next_state == RUN);
    done_d  = (next_state == FIN);
    dir_d   = accept ? (target > position) : dir;
    phase_d = pos_to_phase(pos_next[1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      dir      <= 1'b0;
      quad_a   <= 1'b0;
      quad_b   <= 1'b0;
      position <= '0;
      target_q <= '0;
      div_q    <= '0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      dir      <= dir_d;
      quad_a   <= phase_d[1];
      quad_b   <= phase_d[0];
      position <= pos_next;
      if (accept) begin
        target_q <= target;
        div_q    <= divisor;
      end
    end
  end

`ifdef QUAD_INDEX_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      index <= 1'b0;
    end else begin
      index <= (pos_next == '0);
    end
  end
`endif

endmodule
